// File: rtl/hill_text_blocker_if.sv
// Character stream in, cipher buffer/handshake out, plus status.
// The blocker sits on the slave side; the feeder/cipher environment drives the master side.
interface hill_text_blocker_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 3,
  parameter int CNT_WIDTH  = 16
);
  localparam int ADDR_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  logic [DATA_WIDTH-1:0] char_in;
  logic                  char_valid;
  logic                  char_last;
  logic                  char_ready;
  logic [DATA_WIDTH-1:0] text_in;
  logic [ADDR_W-1:0]     text_in_addr;
  logic                  text_in_wen;
  logic                  cipher_start;
  logic                  cipher_done;
  logic [CNT_WIDTH-1:0]  blocks_sent;
  logic                  msg_done;
  logic                  busy;
  logic                  timeout_err;

  modport slave (
    input  char_in, char_valid, char_last, cipher_done,
    output char_ready, text_in, text_in_addr, text_in_wen, cipher_start,
           blocks_sent, msg_done, busy, timeout_err
  );

  modport master (
    output char_in, char_valid, char_last, cipher_done,
    input  char_ready, text_in, text_in_addr, text_in_wen, cipher_start,
           blocks_sent, msg_done, busy, timeout_err
  );
endinterface

// File: rtl/hill_text_blocker.sv
// Hill-cipher feeder: filters letters, folds to uppercase, packs BLOCK_SIZE-letter
// blocks into the cipher buffer, pads the final block, fires the cipher and waits
// (with timeout) for its done pulse.
module hill_text_blocker #(
  parameter int                    BLOCK_SIZE     = 3,
  parameter int                    DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] PAD_CHAR       = DATA_WIDTH'(8'h58),
  parameter int                    TIMEOUT_CYCLES = 256,
  parameter int                    CNT_WIDTH      = 16
) (
  input  logic                clk,
  input  logic                rst,
  hill_text_blocker_if.slave  bus
);
  localparam int ADDR_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int TC_W   = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {LOAD, PAD, FIRE, WAIT} state_t;

  state_t                state, state_nxt;
  logic [ADDR_W-1:0]     fill, fill_nxt;
  logic                  last_pending, last_nxt;
  logic [TC_W-1:0]       tcnt, tcnt_nxt;
  logic                  wr, start_nxt, done_nxt, sent_inc, to_set;
  logic [DATA_WIDTH-1:0] wr_data;

  logic [DATA_WIDTH-1:0] text_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  wen_q, start_q, msg_q, to_q;
  logic [CNT_WIDTH-1:0]  sent_q;

  logic                  accept, is_upper, is_lower, is_letter, fill_last;
  logic [DATA_WIDTH-1:0] ch_up;

  assign accept    = bus.char_valid && (state == LOAD);
  assign is_upper  = (bus.char_in >= DATA_WIDTH'(65)) && (bus.char_in <= DATA_WIDTH'(90));
  assign is_lower  = (bus.char_in >= DATA_WIDTH'(97)) && (bus.char_in <= DATA_WIDTH'(122));
  assign is_letter = is_upper || is_lower;
  assign ch_up     = is_lower ? bus.char_in - DATA_WIDTH'(32) : bus.char_in;
  assign fill_last = (fill == ADDR_W'(BLOCK_SIZE - 1));

  // Next-state and per-cycle control decode; fill wraps to 0 as the block's last slot is written.
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill;
    last_nxt  = last_pending;
    tcnt_nxt  = tcnt;
    wr        = 1'b0;
    wr_data   = ch_up;
    start_nxt = 1'b0;
    done_nxt  = 1'b0;
    sent_inc  = 1'b0;
    to_set    = 1'b0;
    case (state)
      LOAD: if (accept) begin
        if (is_letter) begin
          wr       = 1'b1;
          fill_nxt = fill_last ? '0 : fill + ADDR_W'(1);
          if (fill_last) state_nxt = FIRE;
        end
        if (bus.char_last) begin
          last_nxt = 1'b1;
          if (is_letter && fill_last) state_nxt = FIRE;
          else if (fill_nxt != '0)    state_nxt = PAD;
          else begin
            // nothing buffered: message ends here without another block
            done_nxt = 1'b1;
            last_nxt = 1'b0;
          end
        end
      end
      PAD: begin
        wr      = 1'b1;
        wr_data = PAD_CHAR;
        if (fill_last) begin
          fill_nxt  = '0;
          state_nxt = FIRE;
        end else begin
          fill_nxt = fill + ADDR_W'(1);
        end
      end
      FIRE: begin
        start_nxt = 1'b1;
        tcnt_nxt  = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.cipher_done) begin
          sent_inc  = 1'b1;
          fill_nxt  = '0;
          done_nxt  = last_pending;
          last_nxt  = 1'b0;
          state_nxt = LOAD;
        end else if (tcnt == TC_W'(TIMEOUT_CYCLES - 1)) begin
          // cipher hung: drop the block and the message tail
          to_set    = 1'b1;
          fill_nxt  = '0;
          last_nxt  = 1'b0;
          state_nxt = LOAD;
        end else begin
          tcnt_nxt = tcnt + TC_W'(1);
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Datapath and registered outputs; reset aborts any in-flight block.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill         <= '0;
      last_pending <= 1'b0;
      tcnt         <= '0;
      text_q       <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      start_q      <= 1'b0;
      msg_q        <= 1'b0;
      sent_q       <= '0;
      to_q         <= 1'b0;
    end else begin
      fill         <= fill_nxt;
      last_pending <= last_nxt;
      tcnt         <= tcnt_nxt;
      wen_q        <= wr;
      start_q      <= start_nxt;
      msg_q        <= done_nxt;
      if (wr) begin
        text_q <= wr_data;
        addr_q <= fill;
      end
      if (sent_inc) sent_q <= sent_q + CNT_WIDTH'(1);
      if (to_set)   to_q   <= 1'b1;
    end
  end

  assign bus.char_ready   = (state == LOAD);
  assign bus.busy         = (state != LOAD);
  assign bus.text_in      = text_q;
  assign bus.text_in_addr = addr_q;
  assign bus.text_in_wen  = wen_q;
  assign bus.cipher_start = start_q;
  assign bus.msg_done     = msg_q;
  assign bus.blocks_sent  = sent_q;
  assign bus.timeout_err  = to_q;
endmodule

// File: tb/tb_hill_text_blocker.sv
// Bench for hill_text_blocker: directed scenarios plus randomized messages checked
// against a letter-filter/pad/chunk model; a cipher stub answers start with done
// and computes the Hill ciphertext of each block.
module tb_hill_text_blocker;
  localparam int BS = 3, DW = 8, CW = 16, TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hill_text_blocker_if #(.DATA_WIDTH(DW), .BLOCK_SIZE(BS), .CNT_WIDTH(CW)) ifc();

  hill_text_blocker #(
    .BLOCK_SIZE(BS), .DATA_WIDTH(DW), .PAD_CHAR(8'h58),
    .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  int tests = 0, fails = 0, cyc = 0;
  int start_cnt, wen_cnt, msg_cnt, start_cyc, last_wen_cyc, msg_cyc, done_cyc;
  int coinc = 0, rdy_bad = 0, stall_cnt = 0, last_acc_cyc = 0, exp_sent = 0;
  bit busy_seen;
  logic [7:0]  cbuf [3];
  logic [23:0] blk_q[$];
  logic [15:0] wr_q[$];
  logic [23:0] exp_q[$];
  bit stub_en = 1'b1;
  int stub_dly = 5;
  logic [7:0] ct [3];
  int key [9] = '{6, 24, 1, 13, 16, 10, 20, 17, 15};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: record buffer writes, starts, message completions
  initial forever begin
    @(negedge clk);
    if (ifc.text_in_wen === 1'b1) begin
      cbuf[ifc.text_in_addr] = ifc.text_in;
      wr_q.push_back({8'(ifc.text_in_addr), ifc.text_in});
      wen_cnt++;
      last_wen_cyc = cyc;
    end
    if (ifc.cipher_start === 1'b1) begin
      blk_q.push_back({cbuf[0], cbuf[1], cbuf[2]});
      start_cnt++;
      start_cyc = cyc;
      if (ifc.text_in_wen === 1'b1) coinc++;
    end
    if (ifc.msg_done === 1'b1) begin
      msg_cnt++;
      msg_cyc = cyc;
    end
    if (ifc.busy === 1'b1) busy_seen = 1'b1;
    if (ifc.char_ready !== !ifc.busy) rdy_bad++;
  end

  // Cipher stub: on start, compute ciphertext and pulse done stub_dly cycles later
  initial begin
    ifc.cipher_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.cipher_start === 1'b1 && stub_en) begin
        for (int r = 0; r < 3; r++) begin
          int acc;
          acc = 0;
          for (int c = 0; c < 3; c++) acc += key[r*3+c] * (int'(cbuf[c]) - 65);
          ct[r] = 8'(acc % 26 + 65);
        end
        repeat (stub_dly) @(negedge clk);
        ifc.cipher_done = 1'b1;
        done_cyc = cyc;
        @(negedge clk);
        ifc.cipher_done = 1'b0;
      end
    end
  end

  task automatic clear_mon();
    wr_q.delete(); blk_q.delete();
    start_cnt = 0; wen_cnt = 0; msg_cnt = 0; busy_seen = 1'b0; stall_cnt = 0;
  endtask

  task automatic send_q(input logic [7:0] m[$]);
    int w;
    foreach (m[i]) begin
      ifc.char_in = m[i]; ifc.char_valid = 1'b1; ifc.char_last = (i == m.size() - 1);
      w = 0;
      while (ifc.char_ready !== 1'b1 && w < 500) begin @(negedge clk); #1; w++; end
      stall_cnt += w;
      if (ifc.char_ready !== 1'b1) begin
        fails++;
        $display("FAIL send_ready char %0d: ready=%b required 1 within 500 cycles", i, ifc.char_ready);
      end
      @(negedge clk); #1;
    end
    ifc.char_valid = 1'b0; ifc.char_last = 1'b0;
    last_acc_cyc = cyc;
  endtask

  task automatic send_str(input string s);
    logic [7:0] q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    send_q(q);
  endtask

  task automatic wait_msg(input string nm);
    int w;
    w = 0;
    while (msg_cnt == 0 && w < 400) begin @(negedge clk); #1; w++; end
    repeat (3) begin @(negedge clk); #1; end
    tests++;
    if (msg_cnt != 1) begin fails++; $display("FAIL %s msg_done count got %0d required 1", nm, msg_cnt); end
  endtask

  // Reference: keep letters (uppercased), pad to a multiple of 3 with 'X', chunk
  task automatic model_blocks(input logic [7:0] m[$]);
    logic [7:0] l[$];
    exp_q.delete();
    foreach (m[i]) begin
      if (m[i] >= "A" && m[i] <= "Z") l.push_back(m[i]);
      else if (m[i] >= "a" && m[i] <= "z") l.push_back(m[i] - 8'd32);
    end
    while (l.size() % 3 != 0) l.push_back("X");
    for (int b = 0; b < l.size() / 3; b++) exp_q.push_back({l[3*b], l[3*b+1], l[3*b+2]});
  endtask

  task automatic check_reset_vals(input string nm);
    tests++;
    if (ifc.text_in !== 8'd0 || ifc.text_in_addr !== 2'd0 || ifc.text_in_wen !== 1'b0 ||
        ifc.cipher_start !== 1'b0 || ifc.blocks_sent !== 16'd0 || ifc.msg_done !== 1'b0 ||
        ifc.timeout_err !== 1'b0 || ifc.busy !== 1'b0) begin
      fails++;
      $display("FAIL %s outputs text=%h addr=%0d wen=%b start=%b sent=%0d msg=%b to=%b busy=%b required all 0",
               nm, ifc.text_in, ifc.text_in_addr, ifc.text_in_wen, ifc.cipher_start,
               ifc.blocks_sent, ifc.msg_done, ifc.timeout_err, ifc.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk); #1;
    tests++;
    if (ifc.char_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b required 1", ifc.char_ready); end
    exp_sent = 0;
  endtask

  task automatic test_act();
    clear_mon(); stub_dly = 12;
    send_str("ACT");
    tests++;
    if (last_wen_cyc != last_acc_cyc) begin fails++; $display("FAIL act_wen_lat got cyc %0d required %0d", last_wen_cyc, last_acc_cyc); end
    wait_msg("act");
    exp_sent++;
    tests++;
    if (wr_q.size() != 3 || wr_q[0] !== {8'd0, "A"} || wr_q[1] !== {8'd1, "C"} || wr_q[2] !== {8'd2, "T"}) begin
      fails++; $display("FAIL act_writes got %0d writes first %h required A@0 C@1 T@2", wr_q.size(), wr_q.size() > 0 ? wr_q[0] : 16'hffff);
    end
    tests++;
    if (start_cnt != 1 || start_cyc != last_wen_cyc + 1) begin
      fails++; $display("FAIL act_start got count %0d cyc %0d required 1 at %0d", start_cnt, start_cyc, last_wen_cyc + 1);
    end
    tests++;
    if (ifc.blocks_sent !== 16'(exp_sent)) begin fails++; $display("FAIL act_sent got %0d required %0d", ifc.blocks_sent, exp_sent); end
    tests++;
    if (msg_cyc != done_cyc + 1) begin fails++; $display("FAIL act_msg_lat got cyc %0d required %0d", msg_cyc, done_cyc + 1); end
  endtask

  task automatic test_pad();
    clear_mon(); stub_dly = 4;
    send_str("hi!");
    wait_msg("pad");
    exp_sent++;
    tests++;
    if (wr_q.size() != 3 || wr_q[0] !== {8'd0, "H"} || wr_q[1] !== {8'd1, "I"} || wr_q[2] !== {8'd2, "X"}) begin
      fails++; $display("FAIL pad_writes got %0d writes last %h required H@0 I@1 X@2", wr_q.size(), wr_q.size() > 0 ? wr_q[wr_q.size()-1] : 16'hffff);
    end
    tests++;
    if (blk_q.size() != 1 || ifc.blocks_sent !== 16'(exp_sent)) begin
      fails++; $display("FAIL pad_blocks got starts %0d sent %0d required 1 / %0d", blk_q.size(), ifc.blocks_sent, exp_sent);
    end
  endtask

  task automatic test_stream();
    clear_mon(); stub_dly = 8;
    send_str("ABCDE");
    wait_msg("stream");
    exp_sent += 2;
    tests++;
    if (blk_q.size() != 2 || blk_q[0] !== "ABC" || blk_q[1] !== "DEX") begin
      fails++; $display("FAIL stream_blocks got %0d blocks first %h required ABC,DEX", blk_q.size(), blk_q.size() > 0 ? blk_q[0] : 24'h0);
    end
    tests++;
    if (stall_cnt == 0) begin fails++; $display("FAIL stream_stall got %0d stall cycles required >0", stall_cnt); end
    tests++;
    if (ifc.blocks_sent !== 16'(exp_sent)) begin fails++; $display("FAIL stream_sent got %0d required %0d", ifc.blocks_sent, exp_sent); end
  endtask

  task automatic test_nonletters();
    clear_mon();
    send_str(" ,.");
    tests++;
    if (msg_cnt != 1 || msg_cyc != last_acc_cyc) begin
      fails++; $display("FAIL nonletter_msg got count %0d cyc %0d required 1 at %0d", msg_cnt, msg_cyc, last_acc_cyc);
    end
    repeat (5) begin @(negedge clk); #1; end
    tests++;
    if (wen_cnt != 0 || start_cnt != 0 || busy_seen || msg_cnt != 1 || ifc.blocks_sent !== 16'(exp_sent)) begin
      fails++; $display("FAIL nonletter_quiet got wen %0d start %0d busy %0b msg %0d sent %0d required 0 0 0 1 %0d",
                        wen_cnt, start_cnt, busy_seen, msg_cnt, ifc.blocks_sent, exp_sent);
    end
  endtask

  task automatic test_timeout();
    int w, te_cyc;
    clear_mon(); stub_en = 1'b0;
    send_str("ABC");
    w = 0;
    while (ifc.timeout_err !== 1'b1 && w < 100) begin @(negedge clk); #1; w++; end
    te_cyc = cyc;
    tests++;
    if (ifc.timeout_err !== 1'b1 || te_cyc != start_cyc + TO) begin
      fails++; $display("FAIL timeout_rise got err %b at cyc %0d required 1 at %0d", ifc.timeout_err, te_cyc, start_cyc + TO);
    end
    tests++;
    if (ifc.char_ready !== 1'b1 || msg_cnt != 0 || ifc.blocks_sent !== 16'(exp_sent)) begin
      fails++; $display("FAIL timeout_after got ready %b msg %0d sent %0d required 1 0 %0d", ifc.char_ready, msg_cnt, ifc.blocks_sent, exp_sent);
    end
    stub_en = 1'b1; stub_dly = 6;
    clear_mon();
    send_str("XYZ");
    wait_msg("timeout_xyz");
    exp_sent++;
    tests++;
    if (blk_q.size() != 1 || blk_q[0] !== "XYZ" || ifc.blocks_sent !== 16'(exp_sent) || ifc.timeout_err !== 1'b1) begin
      fails++; $display("FAIL timeout_recover got blocks %0d sent %0d err %b required 1 XYZ %0d 1", blk_q.size(), ifc.blocks_sent, exp_sent, ifc.timeout_err);
    end
  endtask

  task automatic test_rst_mid();
    clear_mon(); stub_en = 1'b0;
    send_str("ABC");
    repeat (4) begin @(negedge clk); #1; end
    rst = 1'b1;
    @(negedge clk); #1;
    check_reset_vals("rst_wait");
    rst = 1'b0; exp_sent = 0;
    clear_mon();
    repeat (30) begin @(negedge clk); #1; end
    tests++;
    if (wen_cnt != 0 || start_cnt != 0) begin fails++; $display("FAIL rst_wait_stray got wen %0d start %0d required 0 0", wen_cnt, start_cnt); end
    clear_mon();
    send_str("A");
    rst = 1'b1;
    @(negedge clk); #1;
    check_reset_vals("rst_pad");
    rst = 1'b0;
    repeat (30) begin @(negedge clk); #1; end
    tests++;
    if (wen_cnt != 1 || start_cnt != 0) begin fails++; $display("FAIL rst_pad_stray got wen %0d start %0d required 1 0", wen_cnt, start_cnt); end
    stub_en = 1'b1;
  endtask

  task automatic test_cipher();
    clear_mon(); stub_dly = 7;
    send_str("act");
    wait_msg("cipher");
    exp_sent++;
    tests++;
    if ({ct[0], ct[1], ct[2]} !== "POH" || blk_q.size() != 1 || blk_q[0] !== "ACT") begin
      fails++; $display("FAIL cipher_out got %s from %0d blocks required POH", {ct[0], ct[1], ct[2]}, blk_q.size());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      logic [7:0] m[$];
      int len;
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 3))
          0: m.push_back(8'(65 + $urandom_range(0, 25)));
          1: m.push_back(8'(97 + $urandom_range(0, 25)));
          2: m.push_back(8'($urandom_range(32, 64)));
          default: m.push_back(8'(123 + $urandom_range(0, 3)));
        endcase
      end
      model_blocks(m);
      clear_mon(); stub_dly = $urandom_range(1, 12);
      send_q(m);
      wait_msg("random");
      exp_sent += exp_q.size();
      tests++;
      if (blk_q.size() != exp_q.size()) begin
        fails++; $display("FAIL random_%0d block count got %0d required %0d", n, blk_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[b]) begin
          tests++;
          if (blk_q[b] !== exp_q[b]) begin fails++; $display("FAIL random_%0d block %0d got %h required %h", n, b, blk_q[b], exp_q[b]); end
        end
      end
      tests++;
      if (ifc.blocks_sent !== 16'(exp_sent)) begin fails++; $display("FAIL random_%0d sent got %0d required %0d", n, ifc.blocks_sent, exp_sent); end
    end
  endtask

  initial begin
    ifc.char_in = '0; ifc.char_valid = 1'b0; ifc.char_last = 1'b0;
    test_reset();
    test_act();
    test_pad();
    test_stream();
    test_nonletters();
    test_timeout();
    test_rst_mid();
    test_cipher();
    test_random();
    tests++;
    if (coinc != 0) begin fails++; $display("FAIL start_wen_overlap got %0d required 0", coinc); end
    tests++;
    if (rdy_bad != 0) begin fails++; $display("FAIL ready_vs_busy got %0d bad cycles required 0", rdy_bad); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
